// File: rtl/heap_pkg.sv
// Shared types and width helpers for the heap arena and its storage.
package heap_pkg;

  typedef enum logic [2:0] {
    OP_ALLOC = 3'd0,
    OP_FREE  = 3'd1,
    OP_READ  = 3'd2,
    OP_WRITE = 3'd3,
    OP_SIZE  = 3'd4,
    OP_PUSH  = 3'd5
  } heap_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RD_WAIT = 2'd2
  } heap_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 12;
  localparam int unsigned DEF_N_ARRAYS   = 16;
  localparam int unsigned DEF_N_AREA     = 8;

  function automatic int unsigned array_w(input int unsigned n_arrays);
    return $clog2(n_arrays);
  endfunction

  function automatic int unsigned area_w(input int unsigned n_area);
    return $clog2(n_area);
  endfunction

  // Sizes run 0..N_AREA inclusive, hence the +1.
  function automatic int unsigned size_w(input int unsigned n_area);
    return $clog2(n_area + 1);
  endfunction

endpackage

// File: rtl/heap_ram.sv
// Single-port synchronous RAM, read-first with a registered read port.
module heap_ram #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 128
) (
  input  logic                     clock,
  input  logic                     write,
  input  logic [$clog2(DEPTH)-1:0] address,
  input  logic [DATA_WIDTH-1:0]    in,
  output logic [DATA_WIDTH-1:0]    out
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write) mem[address] <= in;
    out <= mem[address];
  end

endmodule

// File: rtl/heap_arena.sv
// Array-allocating heap front end: id allocation with LIFO reuse, per-array
// length tracking, bounds checks and a req/ready/done handshake over one RAM.
module heap_arena
  import heap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned N_ARRAYS   = DEF_N_ARRAYS,
  parameter int unsigned N_AREA     = DEF_N_AREA
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req,
  input  logic [2:0]                      op,
  input  logic [$clog2(N_ARRAYS)-1:0]     array,
  input  logic [DATA_WIDTH-1:0]           index,
  input  logic [DATA_WIDTH-1:0]           data,
  output logic                            ready,
  output logic                            done,
  output logic                            error,
  output logic [DATA_WIDTH-1:0]           result,
  output logic [$clog2(N_ARRAYS+1)-1:0]   alloc_max
);

  localparam int unsigned ARRAY_W = array_w(N_ARRAYS);
  localparam int unsigned AREA_W  = area_w(N_AREA);
  localparam int unsigned SIZE_W  = size_w(N_AREA);
  localparam int unsigned CNT_W   = $clog2(N_ARRAYS + 1);
  localparam int unsigned DEPTH   = N_ARRAYS * N_AREA;
  localparam int unsigned ADDR_W  = ARRAY_W + AREA_W;

  heap_state_t state, state_next;

  logic [2:0]            op_q;
  logic [ARRAY_W-1:0]    array_q;
  logic [DATA_WIDTH-1:0] index_q, data_q;

  logic [N_ARRAYS-1:0]   allocated;
  logic [SIZE_W-1:0]     sizes [N_ARRAYS];
  logic [ARRAY_W-1:0]    stack [N_ARRAYS];
  logic [CNT_W-1:0]      sp, in_use, in_use_inc;
  // Wraps harmlessly: once every id is handed out, reuse goes through the stack.
  logic [ARRAY_W-1:0]    fresh;

  logic                  ready_next, done_next, error_next;
  logic [DATA_WIDTH-1:0] result_next;
  logic                  capture, alloc_go, free_go, size_we, ram_we;
  logic [ARRAY_W-1:0]    size_id, alloc_id;
  logic [SIZE_W-1:0]     size_val, cur_size, idx_len;
  logic                  cur_alloc;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_out;

  assign cur_alloc  = allocated[array_q];
  assign cur_size   = sizes[array_q];
  assign idx_len    = SIZE_W'(index_q[AREA_W-1:0]) + SIZE_W'(1);
  assign alloc_id   = (sp != '0) ? stack[ARRAY_W'(sp - CNT_W'(1))] : fresh;
  assign in_use_inc = in_use + CNT_W'(1);

  heap_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clock   (clock),
    .write   (ram_we),
    .address (ram_addr),
    .in      (data_q),
    .out     (ram_out)
  );

  // Next-state, checks and bookkeeping strobes.
  always_comb begin
    state_next  = state;
    done_next   = 1'b0;
    error_next  = 1'b0;
    result_next = result;
    capture     = 1'b0;
    alloc_go    = 1'b0;
    free_go     = 1'b0;
    size_we     = 1'b0;
    size_id     = array_q;
    size_val    = '0;
    ram_we      = 1'b0;
    ram_addr    = {array_q, index_q[AREA_W-1:0]};

    case (state)
      ST_IDLE: begin
        if (req && ready) begin
          capture    = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
        case (op_q)
          OP_ALLOC: begin
            if (in_use == CNT_W'(N_ARRAYS)) error_next = 1'b1;
            else begin
              alloc_go    = 1'b1;
              size_we     = 1'b1;
              size_id     = alloc_id;
              result_next = DATA_WIDTH'(alloc_id);
            end
          end
          OP_FREE: begin
            if (!cur_alloc) error_next = 1'b1;
            else begin
              free_go     = 1'b1;
              size_we     = 1'b1;
              result_next = DATA_WIDTH'(array_q);
            end
          end
          OP_READ: begin
            if (!cur_alloc || index_q >= DATA_WIDTH'(cur_size)) error_next = 1'b1;
            else begin
              state_next = ST_RD_WAIT;
              done_next  = 1'b0;
            end
          end
          OP_WRITE: begin
            // Full-width compare so large indices cannot alias after truncation.
            if (!cur_alloc || index_q >= DATA_WIDTH'(N_AREA)) error_next = 1'b1;
            else begin
              ram_we      = 1'b1;
              result_next = data_q;
              if (idx_len > cur_size) begin
                size_we  = 1'b1;
                size_val = idx_len;
              end
            end
          end
          OP_SIZE: begin
            if (!cur_alloc) error_next = 1'b1;
            else result_next = DATA_WIDTH'(cur_size);
          end
          OP_PUSH: begin
            if (!cur_alloc || cur_size == SIZE_W'(N_AREA)) error_next = 1'b1;
            else begin
              ram_we      = 1'b1;
              ram_addr    = {array_q, cur_size[AREA_W-1:0]};
              size_we     = 1'b1;
              size_val    = cur_size + SIZE_W'(1);
              result_next = DATA_WIDTH'(cur_size);
            end
          end
          default: error_next = 1'b1;
        endcase
        if (error_next) result_next = '0;
      end
      ST_RD_WAIT: begin
        state_next  = ST_IDLE;
        done_next   = 1'b1;
        result_next = ram_out;
      end
      default: state_next = ST_IDLE;
    endcase

    ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      result    <= '0;
      alloc_max <= '0;
      in_use    <= '0;
      sp        <= '0;
      fresh     <= '0;
      allocated <= '0;
      op_q      <= '0;
      array_q   <= '0;
      index_q   <= '0;
      data_q    <= '0;
      for (int i = 0; i < N_ARRAYS; i++) sizes[i] <= '0;
    end else begin
      state  <= state_next;
      ready  <= ready_next;
      done   <= done_next;
      error  <= error_next;
      result <= result_next;
      if (capture) begin
        op_q    <= op;
        array_q <= array;
        index_q <= index;
        data_q  <= data;
      end
      if (size_we) sizes[size_id] <= size_val;
      if (alloc_go) begin
        allocated[alloc_id] <= 1'b1;
        in_use              <= in_use_inc;
        if (sp != '0) sp <= sp - CNT_W'(1);
        else          fresh <= fresh + ARRAY_W'(1);
        if (in_use_inc > alloc_max) alloc_max <= in_use_inc;
      end
      if (free_go) begin
        allocated[array_q] <= 1'b0;
        in_use             <= in_use - CNT_W'(1);
        sp                 <= sp + CNT_W'(1);
      end
    end
  end

  // Freed-id stack storage; emptiness is tracked by sp alone.
  always_ff @(posedge clock) begin
    if (reset && free_go) stack[ARRAY_W'(sp)] <= array_q;
  end

endmodule

// File: tb/tb_heap_arena.sv
// Directed plan plus randomized ops against a queue/array reference model.
module tb_heap_arena;

  localparam int DW = 12;
  localparam int NA = 4;
  localparam int NR = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req   = 1'b0;
  logic [2:0]  op    = '0;
  logic [1:0]  array = '0;
  logic [11:0] index = '0;
  logic [11:0] data  = '0;
  logic        ready, done, error;
  logic [11:0] result;
  logic [2:0]  alloc_max;

  int total = 0;
  int bad   = 0;

  bit m_alloc [NA];
  int m_size  [NA];
  int m_mem   [NA*NR];
  bit m_known [NA*NR];
  int m_free  [$];
  int m_fresh, m_in_use, m_amax;

  heap_arena #(.DATA_WIDTH(DW), .N_ARRAYS(NA), .N_AREA(NR)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .op        (op),
    .array     (array),
    .index     (index),
    .data      (data),
    .ready     (ready),
    .done      (done),
    .error     (error),
    .result    (result),
    .alloc_max (alloc_max)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NA; k++) begin m_alloc[k] = 0; m_size[k] = 0; end
    m_free.delete();
    m_fresh = 0; m_in_use = 0; m_amax = 0;
  endtask

  // Behavioural rules: returns expected error/result/latency and updates model.
  task automatic model_op(input int o, input int a, input int i, input int d,
                          output bit e, output int r, output int lat, output bit known);
    int id;
    e = 0; r = 0; lat = 1; known = 1;
    case (o)
      0: if (m_in_use == NA) e = 1;
         else begin
           if (m_free.size() > 0) id = m_free.pop_back();
           else begin id = m_fresh; m_fresh++; end
           m_alloc[id] = 1; m_size[id] = 0; m_in_use++;
           if (m_in_use > m_amax) m_amax = m_in_use;
           r = id;
         end
      1: if (!m_alloc[a]) e = 1;
         else begin
           m_alloc[a] = 0; m_free.push_back(a); m_size[a] = 0; m_in_use--; r = a;
         end
      2: if (!m_alloc[a] || i >= m_size[a]) e = 1;
         else begin lat = 2; r = m_mem[a*NR+i]; known = m_known[a*NR+i]; end
      3: if (!m_alloc[a] || i >= NR) e = 1;
         else begin
           m_mem[a*NR+i] = d; m_known[a*NR+i] = 1;
           if (i + 1 > m_size[a]) m_size[a] = i + 1;
           r = d;
         end
      4: if (!m_alloc[a]) e = 1; else r = m_size[a];
      5: if (!m_alloc[a] || m_size[a] == NR) e = 1;
         else begin
           m_mem[a*NR+m_size[a]] = d; m_known[a*NR+m_size[a]] = 1;
           r = m_size[a]; m_size[a]++;
         end
      default: e = 1;
    endcase
    if (e) r = 0;
  endtask

  task automatic run_op(input string tag, input int o, input int a, input int i, input int d,
                        output int res, output bit err);
    bit e, known;
    int r, lat, cyc;
    model_op(o, a, i, d, e, r, lat, known);
    @(negedge clock);
    check({tag, ".ready_idle"}, 32'(ready), 32'd1);
    req = 1'b1; op = 3'(o); array = 2'(a); index = 12'(i); data = 12'(d);
    @(posedge clock); #1;
    req = 1'b0; op = 3'($urandom); array = 2'($urandom); index = 12'($urandom); data = 12'($urandom);
    check({tag, ".busy"}, {30'd0, ready, done}, 32'd0);
    cyc = 0;
    do begin @(posedge clock); #1; cyc++; end while (!done && cyc < 4);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".lat"}, 32'(cyc), 32'(lat));
    check({tag, ".err"}, 32'(error), 32'(e));
    if (known) check({tag, ".res"}, 32'(result), 32'(r));
    check({tag, ".amax"}, 32'(alloc_max), 32'(m_amax));
    check({tag, ".ready_done"}, 32'(ready), 32'd1);
    res = int'(result); err = error;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int res, sel, o, a, i;
    bit err;
    for (int k = 0; k < NA*NR; k++) begin m_mem[k] = 0; m_known[k] = 0; end

    do_reset();
    check("rst.outs", {ready, done, error, result, alloc_max}, {1'b1, 1'b0, 1'b0, 12'd0, 3'd0});

    run_op("alloc0", 0, 0, 0, 0, res, err); check("alloc0.lit", 32'(res), 32'd0);
    run_op("alloc1", 0, 0, 0, 0, res, err); check("alloc1.lit", 32'(res), 32'd1);
    run_op("alloc2", 0, 0, 0, 0, res, err); check("alloc2.lit", 32'(res), 32'd2);
    check("amax3", 32'(alloc_max), 32'd3);

    run_op("wr13", 3, 1, 3, 12'h5A5, res, err);
    run_op("size1", 4, 1, 0, 0, res, err); check("size1.lit", 32'(res), 32'd4);
    run_op("rd13", 2, 1, 3, 0, res, err); check("rd13.lit", 32'(res), 32'h5A5);
    run_op("rd14", 2, 1, 4, 0, res, err); check("rd14.err", 32'(err), 32'd1);

    run_op("free1", 1, 1, 0, 0, res, err);
    run_op("free2", 1, 2, 0, 0, res, err);
    run_op("lifo_a", 0, 0, 0, 0, res, err); check("lifo_a.lit", 32'(res), 32'd2);
    run_op("lifo_b", 0, 0, 0, 0, res, err); check("lifo_b.lit", 32'(res), 32'd1);
    run_op("size2", 4, 2, 0, 0, res, err); check("size2.lit", 32'(res), 32'd0);
    check("amax_keep", 32'(alloc_max), 32'd3);

    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_op("fill", 0, 0, 0, 0, res, err); check("fill.lit", 32'(res), 32'(k));
    end
    run_op("alloc_full", 0, 0, 0, 0, res, err); check("alloc_full.err", 32'(err), 32'd1);
    check("amax4", 32'(alloc_max), 32'd4);
    run_op("free3a", 1, 3, 0, 0, res, err);
    run_op("free3b", 1, 3, 0, 0, res, err); check("free3b.err", 32'(err), 32'd1);

    for (int k = 0; k < 8; k++) begin
      run_op("push", 5, 0, 0, 10 + k, res, err); check("push.lit", 32'(res), 32'(k));
    end
    run_op("push_full", 5, 0, 0, 99, res, err); check("push_full.err", 32'(err), 32'd1);
    run_op("wr_idx8", 3, 0, 8, 1, res, err); check("wr_idx8.err", 32'(err), 32'd1);
    run_op("wr_alias", 3, 0, 12'h800, 1, res, err);
    run_op("op7", 7, 0, 0, 0, res, err); check("op7.err", 32'(err), 32'd1);
    run_op("op6", 6, 0, 0, 0, res, err);
    run_op("rd05", 2, 0, 5, 0, res, err); check("rd05.lit", 32'(res), 32'd15);

    // Reset while a READ sits in its RAM wait cycle.
    @(negedge clock);
    req = 1'b1; op = 3'd2; array = 2'd0; index = 12'd5;
    @(posedge clock); #1 req = 1'b0;
    @(posedge clock); #1;
    check("rdw.busy", {30'd0, ready, done}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rdw.rst", {30'd0, ready, done}, 32'd2);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("rdw.after", {30'd0, ready, done}, 32'd2);
    end
    run_op("post_rst", 0, 0, 0, 0, res, err); check("post_rst.lit", 32'(res), 32'd0);
    check("post_rst.amax", 32'(alloc_max), 32'd1);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if      (sel < 15) o = 0;
      else if (sel < 25) o = 1;
      else if (sel < 45) o = 2;
      else if (sel < 65) o = 3;
      else if (sel < 75) o = 4;
      else if (sel < 95) o = 5;
      else               o = $urandom_range(6, 7);
      a = $urandom_range(0, NA - 1);
      sel = $urandom_range(0, 99);
      if      (sel < 80) i = $urandom_range(0, NR);
      else if (sel < 90) i = 12'h800 | $urandom_range(0, NR - 1);
      else               i = $urandom_range(0, 4095);
      run_op("rand", o, a, i, $urandom_range(0, 4095), res, err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
